// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO with a valid/ready write port.
// Frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [3:0]            idx_q, idx_n;
  logic                  tx_q, tx_n;
  logic [DATA_BITS-1:0]  shift_q, shift_n;
  logic                  par_q, par_n;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           level_q;
  logic                  wr, pop, empty, full, bit_end;
  logic [DATA_BITS-1:0]  head;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    if (PARITY == 1) return ~^w;
    else             return ^w;
  endfunction

  assign full       = (level_q == FULL_LVL);
  assign empty      = (level_q == '0);
  assign in_ready   = !full;
  assign wr         = in_valid && !full;
  assign head       = mem[rptr_q];
  assign bit_end    = (cnt_q == CNT_LAST);
  assign tx         = tx_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE) || !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      tx_q    <= tx_n;
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      case ({wr, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Frame data and storage need no reset; control decides when they matter.
  always_ff @(posedge clk) begin
    shift_q <= shift_n;
    par_q   <= par_n;
    if (wr) mem[wptr_q] <= in_data;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CW'(1);
    idx_n   = idx_q;
    tx_n    = tx_q;
    shift_n = shift_q;
    par_n   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = parity_of(head);
          state_n = S_START;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx_q == LAST_DATA) begin
            idx_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx_q + 4'd1;
            shift_n = shift_q >> 1;
            tx_n    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx_q == LAST_STOP) begin
            idx_n = '0;
            // Chain straight into the next start bit when more data waits.
            if (!empty) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = parity_of(head);
              state_n = S_START;
              tx_n    = 1'b0;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame formats, FIFO fill/drop, chaining, mid-frame reset.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 8N1
  logic a_valid = 0, a_ready, a_tx, a_busy;
  logic [7:0] a_data = 0;
  logic [2:0] a_level;
  // 8E1
  logic e_valid = 0, e_ready, e_tx, e_busy;
  logic [7:0] e_data = 0;
  logic [2:0] e_level;
  // 8O1
  logic o_valid = 0, o_ready, o_tx, o_busy;
  logic [7:0] o_data = 0;
  logic [2:0] o_level;
  // 7N2
  logic s_valid = 0, s_ready, s_tx, s_busy;
  logic [6:0] s_data = 0;
  logic [2:0] s_level;

  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .tx(a_tx), .busy(a_busy), .fifo_level(a_level));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .in_valid(e_valid), .in_data(e_data), .in_ready(e_ready),
    .tx(e_tx), .busy(e_busy), .fifo_level(e_level));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
    .clk(clk), .rst(rst), .in_valid(o_valid), .in_data(o_data), .in_ready(o_ready),
    .tx(o_tx), .busy(o_busy), .fifo_level(o_level));
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_ready(s_ready),
    .tx(s_tx), .busy(s_busy), .fifo_level(s_level));

  // Expected line level of bit b (0=start, 1..8 data, 9 stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_ready, a_level} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      bad++; $display("FAIL reset_a tx/busy/ready/level=%b %b %b %0d want 1 0 1 0", a_tx, a_busy, a_ready, a_level);
    end
    total++;
    if ({e_tx, o_tx, s_tx, e_busy, o_busy, s_busy} !== 6'b111000) begin
      bad++; $display("FAIL reset_others tx=%b%b%b busy=%b%b%b want 111 000", e_tx, o_tx, s_tx, e_busy, o_busy, s_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_tx, a_busy, a_ready, a_level} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      bad++; $display("FAIL post_reset tx/busy/ready/level=%b %b %b %0d want 1 0 1 0", a_tx, a_busy, a_ready, a_level);
    end
  endtask

  task automatic test_8n1();
    logic [9:0] exp = 10'b1001100010;
    a_valid = 1; a_data = 8'h31;
    @(posedge clk);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a_valid = 0;
        total++;
        if ({a_tx, a_level, a_busy} !== {1'b1, 3'd1, 1'b1}) begin
          bad++; $display("FAIL n1_latency tx/level/busy=%b %0d %b want 1 1 1", a_tx, a_level, a_busy);
        end
      end else if (k <= 40) begin
        total++;
        if (a_tx !== exp[(k-1)/4]) begin
          bad++; $display("FAIL n1_bit k=%0d tx=%b want %b", k, a_tx, exp[(k-1)/4]);
        end
      end
      if (k == 40) begin
        total++;
        if (a_busy !== 1'b1) begin bad++; $display("FAIL n1_busy_end busy=%b want 1", a_busy); end
      end
      if (k == 41) begin
        total++;
        if ({a_tx, a_busy, a_level} !== {1'b1, 1'b0, 3'd0}) begin
          bad++; $display("FAIL n1_idle tx/busy/level=%b %b %0d want 1 0 0", a_tx, a_busy, a_level);
        end
      end
    end
  endtask

  task automatic test_parity();
    logic [10:0] exp_e = 11'b11000001110;
    logic [10:0] exp_o = 11'b10000001110;
    e_valid = 1; e_data = 8'h07;
    o_valid = 1; o_data = 8'h07;
    @(posedge clk);
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 0) begin
        e_valid = 0; o_valid = 0;
      end else if (k <= 44) begin
        total++;
        if (e_tx !== exp_e[(k-1)/4]) begin
          bad++; $display("FAIL even_bit k=%0d tx=%b want %b", k, e_tx, exp_e[(k-1)/4]);
        end
        total++;
        if (o_tx !== exp_o[(k-1)/4]) begin
          bad++; $display("FAIL odd_bit k=%0d tx=%b want %b", k, o_tx, exp_o[(k-1)/4]);
        end
      end
      if (k == 44 || k == 45) begin
        total++;
        if ({e_busy, o_busy} !== {2{k == 44}}) begin
          bad++; $display("FAIL parity_busy k=%0d busy=%b%b want %b", k, e_busy, o_busy, {2{k == 44}});
        end
      end
    end
  endtask

  task automatic test_stop2();
    logic [9:0] exp = 10'b1110101010;
    s_valid = 1; s_data = 7'h55;
    @(posedge clk);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_valid = 0;
      end else if (k <= 40) begin
        total++;
        if (s_tx !== exp[(k-1)/4]) begin
          bad++; $display("FAIL stop2_bit k=%0d tx=%b want %b", k, s_tx, exp[(k-1)/4]);
        end
      end
      if (k == 36 || k == 41) begin
        total++;
        if (s_busy !== (k == 36)) begin
          bad++; $display("FAIL stop2_busy k=%0d busy=%b want %b", k, s_busy, k == 36);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6] = '{8'hA5, 8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h5A};
    int idx = 1;
    logic will_accept = 0;
    int exp_lvl, off, f, b;
    logic exp_tx;
    a_valid = 1; a_data = words[0];
    @(posedge clk);
    for (int k = 0; k <= 243; k++) begin
      @(negedge clk);
      if (a_valid && will_accept && k >= 2) idx++;
      if (k >= 1 && idx <= 5) begin a_valid = 1; a_data = words[idx]; end
      else a_valid = 0;
      will_accept = a_ready;
      if (k >= 2 && k <= 42) begin
        exp_lvl = (k <= 5) ? k - 1 : (k <= 40) ? 4 : (k == 41) ? 3 : 4;
        total++;
        if (a_level !== 3'(exp_lvl) || a_ready !== (exp_lvl != 4)) begin
          bad++; $display("FAIL b2b_level k=%0d level=%0d ready=%b want %0d %b", k, a_level, a_ready, exp_lvl, exp_lvl != 4);
        end
      end
      off = k - 1;
      f = off / 40;
      b = (off % 40) / 4;
      exp_tx = (k == 0 || f >= 6) ? 1'b1 : frame_bit(words[f], b);
      total++;
      if (a_tx !== exp_tx) begin
        bad++; $display("FAIL b2b_tx k=%0d tx=%b want %b", k, a_tx, exp_tx);
      end
    end
    total++;
    if ({a_busy, a_level} !== {1'b0, 3'd0}) begin
      bad++; $display("FAIL b2b_drain busy/level=%b %0d want 0 0", a_busy, a_level);
    end
  endtask

  task automatic test_same_edge();
    a_valid = 1; a_data = 8'h0F;
    @(posedge clk);
    for (int k = 0; k <= 121; k++) begin
      @(negedge clk);
      a_valid = 0;
      if (k == 1)  begin a_valid = 1; a_data = 8'hF0; end
      if (k == 40) begin a_valid = 1; a_data = 8'h99; end
      if (k == 2 || k == 40 || k == 41 || k == 80) begin
        total++;
        if (a_level !== 3'd1) begin bad++; $display("FAIL same_level k=%0d level=%0d want 1", k, a_level); end
      end
      if (k == 40 || k == 80) begin
        total++;
        if (a_tx !== 1'b1) begin bad++; $display("FAIL same_stop k=%0d tx=%b want 1", k, a_tx); end
      end
      if (k == 41 || k == 81) begin
        total++;
        if (a_tx !== 1'b0) begin bad++; $display("FAIL same_start k=%0d tx=%b want 0", k, a_tx); end
      end
      if (k == 46) begin
        total++;
        if (a_tx !== 1'b0) begin bad++; $display("FAIL same_y_bit0 tx=%b want 0", a_tx); end
      end
      if (k == 86) begin
        total++;
        if ({a_tx, a_level} !== {1'b1, 3'd0}) begin
          bad++; $display("FAIL same_z_bit0 tx/level=%b %0d want 1 0", a_tx, a_level);
        end
      end
      if (k == 121) begin
        total++;
        if ({a_tx, a_busy} !== 2'b10) begin bad++; $display("FAIL same_idle tx/busy=%b%b want 10", a_tx, a_busy); end
      end
    end
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_data = 8'h00;
    @(posedge clk);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      a_valid = (k == 1 || k == 2);
    end
    total++;
    if ({a_tx, a_level} !== {1'b0, 3'd2}) begin
      bad++; $display("FAIL rmid_pre tx/level=%b %0d want 0 2", a_tx, a_level);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({a_tx, a_level, a_ready, a_busy} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rmid_async tx/level/ready/busy=%b %0d %b %b want 1 0 1 0", a_tx, a_level, a_ready, a_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      total++;
      if ({a_tx, a_busy, a_level} !== {1'b1, 1'b0, 3'd0}) begin
        bad++; $display("FAIL rmid_quiet k=%0d tx/busy/level=%b %b %0d want 1 0 0", k, a_tx, a_busy, a_level);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    test_8n1();
    test_parity();
    test_stop2();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_same_edge();
    @(negedge clk);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an input FIFO and a valid/ready write port. Frame format is set at elaboration time: data width, parity mode, stop-bit count and baud divider. Producers push bytes with a handshake, and frames are sent back-to-back with no idle gap while the FIFO holds data. It drives the USB-UART TX pin and takes the place of single-shot transmit logic in the design.

Parameters:
- BAUD_DIV, 10416, clock cycles per UART bit; must be >= 2.
- DATA_BITS, 8, data bits per frame; range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  producer offers in_data this cycle
- in_data  in  DATA_BITS  word to transmit; bit 0 is sent first
- in_ready  out  1  FIFO can accept a word; equals !full
- tx  out  1  serial output to the UART TX pin; idle high
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of stored words, 0..FIFO_DEPTH

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - tx = 1, FSM = IDLE, FIFO emptied, fifo_level = 0, in_ready = 1, busy = 0.
  - Baud counter and bit index cleared.
- Write:
  - A word is accepted on a clk edge when in_valid && in_ready.
  - If in_valid is asserted while full, the word is dropped and no state changes.
  - A word written into an empty FIFO is not popped in the same cycle.
  - When full, a pop and an offered write in the same cycle accept no write, because in_ready is already 0.
- fifo_level rules:
  - Increments on write only, decrements on pop only.
  - Unchanged when a write and a pop occur on the same edge.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head word into the shift register, compute parity, go to START and drive tx = 0 on that same edge.
  - START: tx = 0 for BAUD_DIV cycles, then go to DATA with tx = shift[0].
  - DATA: each bit is held BAUD_DIV cycles, LSB first, shifting right. After DATA_BITS bits, go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: tx = ^data for even parity, ~^data for odd parity. Held BAUD_DIV cycles, then go to STOP.
  - STOP: tx = 1 for STOP_BITS*BAUD_DIV cycles. On completion, if the FIFO is non-empty, pop and go directly to START (tx goes 1 to 0 on that edge, no idle cycle). Otherwise go to IDLE.
- Timing:
  - The baud counter restarts at 0 on every bit boundary and state entry, so every bit lasts exactly BAUD_DIV cycles.
  - tx is a registered output and changes only on bit boundaries.
  - Latency: a word written at edge E into an empty FIFO, with the FSM in IDLE, drives tx low starting at edge E+1.
  - Frame length = BAUD_DIV*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- The data and parity of a frame are latched at pop. Later FIFO writes never alter a frame in flight.
- busy = (state != IDLE) || (fifo_level != 0).

Test Plan:
- 8N1, BAUD_DIV=4; write 0x31 once -> tx low at edge E+1; tx bits 0,1,0,0,0,1,1,0,0,1, each 4 cycles; then idle high; busy drops after 40 cycles.
- PARITY=2 (even), BAUD_DIV=4; send 0x07 -> parity bit = 1. Repeat with PARITY=1 (odd) -> parity bit = 0. Frame length 44 cycles.
- FIFO_DEPTH=4, FSM busy; write 5 words with in_valid held high -> in_ready falls after the 4th accepted write; the 5th is dropped until a pop; fifo_level runs 1..4. All frames are contiguous with no idle cycle between them.
- STOP_BITS=2, DATA_BITS=7; send 0x55 -> 7 data bits 1,0,1,0,1,0,1, then tx high for 2*BAUD_DIV cycles.
- Assert rst mid-DATA with 2 words queued -> tx = 1 immediately, fifo_level = 0, in_ready = 1; no further frames after release.
- Write on the same edge as a pop at STOP completion -> fifo_level unchanged; next frame starts on that edge.
